// File: rtl/prach_pkg.sv
// Shared PRACH front-end constants; the FFT length here must match the FFT stage.
package prach_pkg;

  localparam int PRACH_NUM_CP  = 198;
  localparam int PRACH_NUM_FFT = 1536;
  localparam int PRACH_NUM_REP = 2;

  // Counter width for a count range of 'range' values, never narrower than 1 bit.
  function automatic int cnt_width(input int range);
    return (range > 1) ? $clog2(range) : 1;
  endfunction

endpackage

// File: rtl/prach_cp_remove.sv
// PRACH cyclic-prefix removal: locates occasions from sync_in, drops the CP and
// forwards NUM_REP back-to-back FFT blocks, each framed by sync_out.
module prach_cp_remove
  import prach_pkg::*;
#(
  parameter int NUM_CP  = PRACH_NUM_CP,
  parameter int NUM_FFT = PRACH_NUM_FFT,
  parameter int NUM_REP = PRACH_NUM_REP
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] din_dr,
  input  logic [15:0] din_di,
  input  logic        din_dv,
  input  logic        sync_in,
  output logic [15:0] dout_dr,
  output logic [15:0] dout_di,
  output logic        dout_dv,
  output logic        sync_out,
  output logic        err_resync
);

  localparam int CPW = cnt_width(NUM_CP);
  localparam int FW  = cnt_width(NUM_FFT);
  localparam int RW  = cnt_width(NUM_REP);

  localparam logic [CPW-1:0] CP_LAST  = CPW'((NUM_CP > 0) ? NUM_CP - 1 : 0);
  localparam logic [FW-1:0]  FFT_LAST = FW'(NUM_FFT - 1);
  localparam logic [RW-1:0]  REP_LAST = RW'(NUM_REP - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CP,
    S_DATA
  } state_t;

  state_t          r_state;
  logic [CPW-1:0]  r_cp_cnt;
  logic [FW-1:0]   r_data_cnt;
  logic [RW-1:0]   r_rep_cnt;
  logic [15:0]     r_dout_dr;
  logic [15:0]     r_dout_di;
  logic            r_dout_dv;
  logic            r_sync_out;
  logic            r_err_resync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cp_cnt     <= '0;
      r_data_cnt   <= '0;
      r_rep_cnt    <= '0;
      r_dout_dr    <= '0;
      r_dout_di    <= '0;
      r_dout_dv    <= 1'b0;
      r_sync_out   <= 1'b0;
      r_err_resync <= 1'b0;
    end else begin
      r_dout_dr    <= '0;
      r_dout_di    <= '0;
      r_dout_dv    <= 1'b0;
      r_sync_out   <= 1'b0;
      r_err_resync <= 1'b0;
      if (din_dv) begin
        if (sync_in) begin
          // Sync wins in every state: it always opens a new occasion on this sample.
          r_err_resync <= (r_state != S_IDLE);
          r_rep_cnt    <= '0;
          r_cp_cnt     <= '0;
          r_data_cnt   <= '0;
          if (NUM_CP == 0) begin
            r_state    <= S_DATA;
            r_dout_dr  <= din_dr;
            r_dout_di  <= din_di;
            r_dout_dv  <= 1'b1;
            r_sync_out <= 1'b1;
            r_data_cnt <= FW'(1);
          end else if (NUM_CP == 1) begin
            r_state <= S_DATA;
          end else begin
            r_state  <= S_CP;
            r_cp_cnt <= CPW'(1);
          end
        end else begin
          case (r_state)
            S_CP: begin
              if (r_cp_cnt == CP_LAST) begin
                r_state    <= S_DATA;
                r_cp_cnt   <= '0;
                r_data_cnt <= '0;
              end else begin
                r_cp_cnt <= r_cp_cnt + CPW'(1);
              end
            end
            S_DATA: begin
              r_dout_dr  <= din_dr;
              r_dout_di  <= din_di;
              r_dout_dv  <= 1'b1;
              r_sync_out <= (r_data_cnt == '0);
              if (r_data_cnt == FFT_LAST) begin
                r_data_cnt <= '0;
                if (r_rep_cnt == REP_LAST) begin
                  r_state   <= S_IDLE;
                  r_rep_cnt <= '0;
                end else begin
                  r_rep_cnt <= r_rep_cnt + RW'(1);
                end
              end else begin
                r_data_cnt <= r_data_cnt + FW'(1);
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign dout_dr    = r_dout_dr;
  assign dout_di    = r_dout_di;
  assign dout_dv    = r_dout_dv;
  assign sync_out   = r_sync_out;
  assign err_resync = r_err_resync;

endmodule
